// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // IDLE: one cycle after reset before the first request.
    // FETCH: request outstanding.
    // HOLD: skid occupied while decode stalls.
    // DRAIN: wait out a request that a redirect made stale.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer: catches an instruction returned while decode is stalled.
module fetch_skid
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_inst,
    input  logic [ADDR_W-1:0]  load_pc4,
    output logic               valid,
    output logic [INSTR_W-1:0] inst,
    output logic [ADDR_W-1:0]  pc4
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] inst_q,  inst_d;
    logic [ADDR_W-1:0]  pc4_q,   pc4_d;

    // Next entry contents: clear beats load beats unload.
    always_comb begin
        // NOTE: every _d starts at its held value so no path can leave it unassigned and infer a latch.
        valid_d = valid_q;
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        if (clear) begin
            valid_d = 1'b0;
            inst_d  = '0;
            pc4_d   = '0;
        end else if (load) begin
            valid_d = 1'b1;
            inst_d  = load_inst;
            pc4_d   = load_pc4;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    // Entry registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the data fields are reset too, so nothing downstream can ever observe X from an unused entry.
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc4_q   <= '0;
        end else begin
            // NOTE: non-blocking assignment so all flops sample pre-edge values regardless of statement order.
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid = valid_q;
    assign inst  = inst_q;
    assign pc4   = pc4_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control: PC, req/ack memory handshake, stall skid and branch flush.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_inst,
    output logic [ADDR_W-1:0]  if_pc4
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    fetch_state_t       state_q,    state_d;
    logic [ADDR_W-1:0]  pc_q,       pc_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic               if_valid_q, if_valid_d;
    logic [INSTR_W-1:0] if_inst_q,  if_inst_d;
    logic [ADDR_W-1:0]  if_pc4_q,   if_pc4_d;

    logic               sk_load, sk_unload, sk_clear, sk_valid;
    logic [INSTR_W-1:0] sk_inst;
    logic [ADDR_W-1:0]  sk_pc4;
    logic [ADDR_W-1:0]  seq_pc4;

    // Wraps modulo 2^ADDR_W; no alignment is enforced.
    assign seq_pc4 = req_addr_q + PC_STEP;

    fetch_skid #(.ADDR_W(ADDR_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (sk_load),
        .unload    (sk_unload),
        .clear     (sk_clear),
        .load_inst (imem_rdata),
        .load_pc4  (seq_pc4),
        .valid     (sk_valid),
        .inst      (sk_inst),
        .pc4       (sk_pc4)
    );

    // Next-state and datapath decisions; redirect beats ack, ack beats stall.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        if_valid_d = if_valid_q;
        if_inst_d  = if_inst_q;
        if_pc4_d   = if_pc4_q;
        sk_load    = 1'b0;
        sk_unload  = 1'b0;
        sk_clear   = 1'b0;

        case (state_q)
            IDLE: begin
                req_addr_d = pc_q;
                state_d    = FETCH;
            end

            FETCH: begin
                if (br_taken) begin
                    if_valid_d = 1'b0;
                    pc_d       = br_target;
                    if (imem_ack) begin
                        req_addr_d = br_target;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_d = seq_pc4;
                    if (!stall) begin
                        if_inst_d  = imem_rdata;
                        if_pc4_d   = seq_pc4;
                        if_valid_d = 1'b1;
                        req_addr_d = seq_pc4;
                    end else begin
                        sk_load = 1'b1;
                        state_d = HOLD;
                    end
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                end
            end

            HOLD: begin
                if (br_taken) begin
                    sk_clear   = 1'b1;
                    if_valid_d = 1'b0;
                    pc_d       = br_target;
                    req_addr_d = br_target;
                    state_d    = FETCH;
                end else if (!stall) begin
                    sk_unload  = 1'b1;
                    if_inst_d  = sk_inst;
                    if_pc4_d   = sk_pc4;
                    if_valid_d = sk_valid;
                    req_addr_d = pc_q;
                    state_d    = FETCH;
                end
            end

            DRAIN: begin
                if_valid_d = 1'b0;
                if (br_taken) begin
                    pc_d = br_target;
                end
                // The stale handshake completes here; the latest redirect supplies the new address.
                if (imem_ack) begin
                    req_addr_d = br_taken ? br_target : pc_q;
                    state_d    = FETCH;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State, PC and IF/ID output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            if_valid_q <= 1'b0;
            if_inst_q  <= '0;
            if_pc4_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            if_valid_q <= if_valid_d;
            if_inst_q  <= if_inst_d;
            if_pc4_q   <= if_pc4_d;
        end
    end

    // Request follows state directly, so it drops the instant reset asserts.
    assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr = req_addr_q;
    assign if_valid  = if_valid_q;
    assign if_inst   = if_inst_q;
    assign if_pc4    = if_pc4_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios then random traffic against a transaction model.
module tb_fetch_sequencer;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_inst    (if_inst),
        .if_pc4     (if_pc4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } word_t;

    bit          m_idle;    // first cycle after reset, nothing requested yet
    bit          m_req;     // a request is on the bus
    bit          m_stale;   // the request on the bus belongs to a flushed path
    logic [31:0] m_addr;    // address on the bus
    logic [31:0] m_pc;      // where sequential fetch continues
    bit          m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_pc4;
    word_t       m_buf[$];  // instruction caught during a stall

    task automatic model_reset();
        m_idle  = 1'b1;
        m_req   = 1'b0;
        m_stale = 1'b0;
        m_addr  = 32'h0;
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_inst  = 32'h0;
        m_pc4   = 32'h0;
        m_buf.delete();
    endtask

    task automatic present(input word_t w);
        m_valid = 1'b1;
        m_inst  = w.inst;
        m_pc4   = w.pc4;
    endtask

    task automatic model_update(input bit s, input bit b, input logic [31:0] t,
                                input bit a, input logic [31:0] d);
        word_t w;
        if (m_idle) begin
            m_idle = 1'b0;
            m_req  = 1'b1;
            m_addr = m_pc;
        end else if (m_req) begin
            if (b) begin
                m_valid = 1'b0;
                m_pc    = t;
                if (a) begin
                    m_addr  = t;
                    m_stale = 1'b0;
                end else begin
                    m_stale = 1'b1;
                end
            end else if (a) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                    m_addr  = m_pc;
                end else begin
                    w.inst = d;
                    w.pc4  = m_addr + 32'd4;
                    m_pc   = w.pc4;
                    if (!s) begin
                        present(w);
                        m_addr = m_pc;
                    end else begin
                        m_buf.push_back(w);
                        m_req = 1'b0;
                    end
                end
            end else if (!s && !m_stale) begin
                m_valid = 1'b0;
            end
        end else begin
            if (b) begin
                m_buf.delete();
                m_valid = 1'b0;
                m_pc    = t;
                m_addr  = t;
                m_req   = 1'b1;
            end else if (!s) begin
                present(m_buf.pop_front());
                m_addr = m_pc;
                m_req  = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check("imem_req", {31'b0, imem_req}, {31'b0, m_req});
        if (m_req) check("imem_addr", imem_addr, m_addr);
        check("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
        check("if_inst", if_inst, m_inst);
        check("if_pc4", if_pc4, m_pc4);
    endtask

    // One clock: drive at the falling edge, compare, let the rising edge act, update the model.
    task automatic step(input bit s, input bit b, input logic [31:0] t, input bit a);
        stall      = s;
        br_taken   = b;
        br_target  = t;
        imem_ack   = a;
        imem_rdata = a ? (m_addr ^ KEY) : $urandom;
        check_outputs();
        @(posedge clk);
        model_update(s, b, t, a, imem_rdata);
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit a);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, a);
    endtask

    // Reset for three cycles; with mid set, reset asserts between clock edges.
    task automatic do_reset(input bit mid);
        stall    = 1'b0;
        br_taken = 1'b0;
        imem_ack = 1'b1;
        if (mid) begin
            #2 reset = 1'b0;
            #1;
            check("async_req_drop", {31'b0, imem_req}, 32'h0);
            check("async_valid_drop", {31'b0, if_valid}, 32'h0);
            @(negedge clk);
        end else begin
            reset = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_req", {31'b0, imem_req}, 32'h0);
            check("rst_valid", {31'b0, if_valid}, 32'h0);
            check("rst_inst", if_inst, 32'h0);
            check("rst_pc4", if_pc4, 32'h0);
        end
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bit          s, b, a;
        logic [31:0] t;
        int          wait_cnt;

        reset      = 1'b1;
        stall      = 1'b0;
        br_taken   = 1'b0;
        br_target  = 32'h0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        #1 reset = 1'b0;
        @(negedge clk);

        // Reset and straight-line zero-wait fetch.
        do_reset(1'b0);
        run(1, 1'b1);
        check("first_req", {31'b0, imem_req}, 32'h1);
        check("first_addr", imem_addr, 32'h0);
        run(1, 1'b1);
        check("first_pc4", if_pc4, 32'h4);
        check("first_inst", if_inst, 32'hA5A5_0000);
        run(7, 1'b1);
        check("stream_pc4", if_pc4, 32'h20);

        // Three wait states per request.
        do_reset(1'b0);
        run(1, 1'b0);
        wait_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            a = (wait_cnt == 3);
            step(1'b0, 1'b0, 32'h0, a);
            wait_cnt = a ? 0 : wait_cnt + 1;
        end
        check("wait_addr", imem_addr, 32'h10);

        // Stall with skid at 0x10.
        do_reset(1'b0);
        run(1, 1'b0);
        run(4, 1'b1);
        check("skid_addr", imem_addr, 32'h10);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("skid_inst", if_inst, 32'h10 ^ KEY);
        check("skid_pc4", if_pc4, 32'h14);
        check("skid_next_addr", imem_addr, 32'h14);
        run(3, 1'b1);

        // Branch while the request to 0x20 waits.
        do_reset(1'b0);
        run(1, 1'b0);
        run(8, 1'b1);
        check("drain_start_addr", imem_addr, 32'h20);
        step(1'b0, 1'b1, 32'h200, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("drain_hold_addr", imem_addr, 32'h20);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("drain_target_addr", imem_addr, 32'h200);
        check("drain_no_valid", {31'b0, if_valid}, 32'h0);
        run(3, 1'b1);

        // Branch + ack + stall together, then PC wrap.
        do_reset(1'b0);
        run(1, 1'b0);
        run(3, 1'b1);
        step(1'b1, 1'b1, 32'h40, 1'b1);
        check("simul_addr", imem_addr, 32'h40);
        check("simul_req", {31'b0, imem_req}, 32'h1);
        run(3, 1'b1);
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("wrap_pc4", if_pc4, 32'h0);
        check("wrap_next_addr", imem_addr, 32'h0);
        run(2, 1'b1);

        // Asynchronous reset while draining.
        do_reset(1'b0);
        run(1, 1'b0);
        run(2, 1'b1);
        step(1'b0, 1'b1, 32'h300, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        do_reset(1'b1);
        run(1, 1'b1);
        check("refetch_addr", imem_addr, 32'h0);
        run(3, 1'b1);

        // Random traffic.
        do_reset(1'b0);
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 9) < 3);
            b = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       t = 32'hFFFF_FFF0;
                1:       t = $urandom;
                default: t = $urandom & 32'h0000_FFFC;
            endcase
            a = ($urandom_range(0, 1) == 1);
            step(s, b, t, a);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control block for the instruction-fetch stage. It owns the program counter, issues instruction-memory requests over a req/ack handshake, absorbs decode-stage stalls with a one-entry skid buffer, and applies branch redirects with flush. Its outputs feed the IF/ID pipeline register. It replaces the free-running PC update whenever instruction memory has variable latency.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- ADDR_W, 32: PC and address width; instruction width is fixed at 32.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; low = in reset.
- stall  in  1  decode cannot accept this cycle; hold `if_*`.
- br_taken  in  1  branch resolved taken this cycle (single-cycle pulse).
- br_target  in  ADDR_W  redirect address, valid with `br_taken`.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  request address; stable while `imem_req` is high and no ack has arrived.
- imem_ack  in  1  memory returns `imem_rdata` this cycle; ignored unless `imem_req` is high.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  `if_inst`/`if_pc4` hold a live instruction.
- if_inst  out  32  instruction to IF/ID.
- if_pc4  out  ADDR_W  fetched address + 4.

## Operation
- **Registers:** `pc`, `req_addr`, FSM state, skid (`sk_inst`, `sk_pc4`), output regs `if_valid`/`if_inst`/`if_pc4`.
- **Reset values:** state=IDLE, `pc`=`req_addr`=RESET_PC, `imem_req`=0, `if_valid`=0, `if_inst`=0, `if_pc4`=0, skid=0.
- **IDLE:** `imem_req`=0. Next cycle: `req_addr`<=`pc`, go to FETCH.
- **FETCH:** `imem_req`=1, `imem_addr`=`req_addr`.
  - `br_taken`, with or without ack: flush. `if_valid`<=0, `pc`<=`br_target`.
    - With ack: `req_addr`<=`br_target`; stay in FETCH; data discarded.
    - Without ack: go to DRAIN; `req_addr` unchanged.
  - ack and !stall: `if_inst`<=`imem_rdata`, `if_pc4`<=`req_addr`+4, `if_valid`<=1, `pc`<=`req_addr`<=`req_addr`+4; stay in FETCH.
  - ack and stall: skid<=(rdata, `req_addr`+4), `pc`<=`req_addr`+4, go to HOLD; `if_*` unchanged.
  - no ack, !stall: `if_valid`<=0 (bubble; the current instruction was consumed).
  - no ack, stall: `if_*` unchanged.
- **HOLD:** `imem_req`=0.
  - `br_taken`: discard skid, `if_valid`<=0, `pc`<=`req_addr`<=`br_target`, go to FETCH.
  - !stall: `if_*`<=skid, `if_valid`<=1, `req_addr`<=`pc`, go to FETCH.
  - stall: stay in HOLD.
- **DRAIN:** `imem_req`=1 with the old `req_addr` (the handshake is never aborted).
  - On ack: discard data, `req_addr`<=`pc`, go to FETCH.
  - `br_taken` again: `pc`<=new `br_target` (last redirect wins); stay in DRAIN.
  - `if_valid` stays 0.
- **Priority:** reset > `br_taken` > ack > `stall`.
- **Arithmetic:** `pc`+4 is modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0. No alignment check.
- **Reset mid-request:** `imem_req` drops asynchronously and any outstanding ack is ignored. Memory must tolerate request withdrawal under reset.

## Timing
- Reset deassert at edge 0: IDLE at cycle 0, first `imem_req` at cycle 1 with address RESET_PC.
- Ack in cycle N (not stalled): `if_valid`/`if_inst` visible in cycle N+1, next request address presented in cycle N+1.
- Zero-wait memory (ack every cycle a request is up): one instruction per cycle.
- `br_taken` in cycle N:
  - `if_valid`=0 in cycle N+1.
  - Target request issued in cycle N+1 if ack or HOLD in cycle N, otherwise the cycle after the DRAIN ack.
- Stall release in HOLD at cycle N: skid visible in cycle N+1, new request in cycle N+1.
- `imem_addr` never changes while `imem_req`=1 and ack has not been seen.

## Structure
- Package `fetch_pkg`:
  - state enum `fetch_state_t` {IDLE, FETCH, HOLD, DRAIN};
  - `INSTR_W`=32 and the default `RESET_PC` constant.
- Sub-module `fetch_skid`: one-entry buffer (load, unload, clear) holding instruction + pc4. FSM, PC logic and output registers stay in `fetch_sequencer`.

## Test plan
- **Reset and straight-line fetch:** reset low 3 cycles, release; 0-wait memory returning addr^32'hA5A5_0000. Expect first request at RESET_PC in cycle 1, `if_pc4`=4,8,12,... one per cycle, all outputs 0 during reset.
- **Wait states:** memory acks 3 cycles after each request. Expect `imem_addr` stable across the wait, `if_valid` pulses once per 4 cycles, bubbles have `if_valid`=0.
- **Stall with skid:** ack at addr 0x10 while `stall`=1 for 4 cycles. Expect `imem_req`=0 in HOLD and `if_*` unchanged. On release, `if_inst`=data@0x10 next cycle and the next request is 0x14.
- **Branch during outstanding request:** `br_taken`, target 0x200, while a request to 0x20 waits 2 cycles. Expect `if_valid`=0, request holds 0x20 until ack, 0x20 data is never valid, next request is 0x200.
- **Simultaneous events:** `br_taken`+ack+`stall` in the same cycle, target 0x40. Expect flush, no HOLD entry, next request 0x40. Separately, PC at 0xFFFF_FFFC wraps: `if_pc4`=0.
- **Async reset mid-DRAIN:** assert reset between clock edges. Expect `imem_req`=0 immediately, and refetch from RESET_PC after release.
